// File: rtl/priority_queue.sv
// Sorted-array priority queue: push inserts in order, pop returns the head; one op per cycle, o_data/o_valid registered.
// Optional PRIORITY_QUEUE_MIN_FIRST_EN makes the head the smallest value instead of the largest.
module priority_queue #(
    parameter int QUEUE_DEPTH = 10,
    parameter int DATA_LENGTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_write,
    input  logic                   i_valid,
    input  logic [DATA_LENGTH-1:0] i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_valid,
    output logic [DATA_LENGTH-1:0] o_data
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [DATA_LENGTH-1:0] r_e [QUEUE_DEPTH];
    logic [CW-1:0]          r_count;
    logic [DATA_LENGTH-1:0] r_data;
    logic                   r_valid;

    logic [DATA_LENGTH-1:0] w_ins [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] w_keep;
    logic                   w_push;
    logic                   w_pop;

    assign o_full  = (r_count == CW'(QUEUE_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_valid = r_valid;
    assign o_data  = r_data;

    assign w_push = i_valid && i_write && !o_full;
    assign w_pop  = i_valid && !i_write && !o_empty;

    // An entry stays in place if it outranks or ties the new word, so equal values leave in FIFO order.
    always_comb begin
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
`ifdef PRIORITY_QUEUE_MIN_FIRST_EN
            w_keep[k] = (CW'(k) < r_count) && (r_e[k] <= i_data);
`else
            w_keep[k] = (CW'(k) < r_count) && (r_e[k] >= i_data);
`endif
        end
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            if (w_keep[k])
                w_ins[k] = r_e[k];
            else if (k == 0)
                w_ins[k] = i_data;
            else if (w_keep[k-1])
                w_ins[k] = i_data;
            else
                w_ins[k] = r_e[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            for (int k = 0; k < QUEUE_DEPTH; k++)
                r_e[k] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_push) begin
                for (int k = 0; k < QUEUE_DEPTH; k++)
                    r_e[k] <= w_ins[k];
                r_count <= r_count + CW'(1);
            end else if (w_pop) begin
                r_data  <= r_e[0];
                r_valid <= 1'b1;
                for (int k = 0; k < QUEUE_DEPTH - 1; k++)
                    r_e[k] <= r_e[k+1];
                r_e[QUEUE_DEPTH-1] <= '0;
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_priority_queue.sv
// Directed bench for priority_queue; expected orderings follow the build's PRIORITY_QUEUE_MIN_FIRST_EN setting.
module tb_priority_queue;
    localparam int D = 10;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         i_write;
    logic         i_valid;
    logic [W-1:0] i_data;
    logic         o_full;
    logic         o_empty;
    logic         o_valid;
    logic [W-1:0] o_data;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] last_pop;

    int push_v[D] = '{12, 1, 2, 14, 12, 3, 0, 20, 25, 13};
`ifdef PRIORITY_QUEUE_MIN_FIRST_EN
    int drain_v[D] = '{0, 1, 2, 3, 12, 12, 13, 14, 20, 25};
    int small_v[4] = '{1, 2, 12, 14};
    int inter_v[3] = '{5, 6, 7};
`else
    int drain_v[D] = '{25, 20, 14, 13, 12, 12, 3, 2, 1, 0};
    int small_v[4] = '{14, 12, 2, 1};
    int inter_v[3] = '{7, 6, 5};
`endif

    priority_queue #(.QUEUE_DEPTH(D), .DATA_LENGTH(W)) dut (
        .CLK(CLK), .RST(RST), .i_write(i_write), .i_valid(i_valid), .i_data(i_data),
        .o_full(o_full), .o_empty(o_empty), .o_valid(o_valid), .o_data(o_data)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic w, input logic [W-1:0] d);
        i_valid = v;
        i_write = w;
        i_data  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        drive(1'b1, 1'b1, 32'd7);
        RST = 1'b0;
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", o_data); end
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_push_ignored got=%b exp=0", o_valid); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b1, W'(push_v[i]));
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL push_valid[%0d] got=%b exp=0", i, o_valid); end
            checks++; if (o_full !== (i == D-1)) begin failures++; $display("FAIL push_full[%0d] got=%b exp=%b", i, o_full, (i == D-1)); end
            checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL push_empty[%0d] got=%b exp=0", i, o_empty); end
        end
        drive(1'b1, 1'b1, 32'd99);
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL full_drop_full got=%b exp=1", o_full); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL full_drop_valid got=%b exp=0", o_valid); end
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL pop_valid[%0d] got=%b exp=1", i, o_valid); end
            checks++; if (o_data !== W'(drain_v[i])) begin failures++; $display("FAIL pop_data[%0d] got=%0d exp=%0d", i, o_data, drain_v[i]); end
            checks++; if (o_empty !== (i == D-1)) begin failures++; $display("FAIL pop_empty[%0d] got=%b exp=%b", i, o_empty, (i == D-1)); end
            checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL pop_full[%0d] got=%b exp=0", i, o_full); end
        end
        last_pop = W'(drain_v[D-1]);
    endtask

    task automatic test_pop_empty;
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== last_pop) begin failures++; $display("FAIL empty_pop_data got=%0d exp=%0d", o_data, last_pop); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL empty_pop_empty got=%b exp=1", o_empty); end
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL empty_idle got=%b exp=1", o_empty); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 32'd5);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_push5_valid got=%b exp=0", o_valid); end
        drive(1'b1, 1'b1, 32'd7);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_push7_valid got=%b exp=0", o_valid); end
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b1 || o_data !== W'(inter_v[0])) begin failures++; $display("FAIL b2b_pop0 got=%b/%0d exp=1/%0d", o_valid, o_data, inter_v[0]); end
        drive(1'b1, 1'b1, 32'd6);
        checks++; if (o_valid !== 1'b0 || o_data !== W'(inter_v[0])) begin failures++; $display("FAIL b2b_push6 got=%b/%0d exp=0/%0d", o_valid, o_data, inter_v[0]); end
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b1 || o_data !== W'(inter_v[1])) begin failures++; $display("FAIL b2b_pop1 got=%b/%0d exp=1/%0d", o_valid, o_data, inter_v[1]); end
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b1 || o_data !== W'(inter_v[2])) begin failures++; $display("FAIL b2b_pop2 got=%b/%0d exp=1/%0d", o_valid, o_data, inter_v[2]); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", o_empty); end
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%b exp=0", o_valid); end
    endtask

    task automatic test_small_order;
        drive(1'b1, 1'b1, 32'd12);
        drive(1'b1, 1'b1, 32'd1);
        drive(1'b1, 1'b1, 32'd2);
        drive(1'b1, 1'b1, 32'd14);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++; if (o_valid !== 1'b1 || o_data !== W'(small_v[i])) begin failures++; $display("FAIL small_pop[%0d] got=%b/%0d exp=1/%0d", i, o_valid, o_data, small_v[i]); end
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 1'b1, 32'd4);
        drive(1'b1, 1'b1, 32'd9);
        drive(1'b1, 1'b1, 32'd3);
        drive(1'b1, 1'b1, 32'd8);
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_data === 32'd0) begin failures++; $display("FAIL mid_prepop got=%0d exp=nonzero", o_data); end
        RST = 1'b1;
        drive(1'b1, 1'b0, 32'd0);
        RST = 1'b0;
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%b exp=1", o_empty); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL mid_rst_full got=%b exp=0", o_full); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL mid_rst_data got=%0d exp=0", o_data); end
        drive(1'b1, 1'b0, 32'd0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_pop_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL mid_rst_pop_data got=%0d exp=0", o_data); end
    endtask

    initial begin
        RST = 1'b1;
        i_valid = 1'b0;
        i_write = 1'b0;
        i_data = '0;
        last_pop = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_fill_drain();
        test_pop_empty();
        test_back_to_back();
        test_small_order();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
